imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning the immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the output buffer entries; legal range is 2..8.
REQ-003 SHALL have one clock; reset is synchronous and active-low; ports CLK and Reset_n.
REQ-004 Port CLK  input  1  is the clock; all state updates on its rising edge.
REQ-005 Port Reset_n  input  1  is the synchronous active-low reset.
REQ-006 Port InValid  input  1  means the request is valid.
REQ-007 Port InReady  output  1  means the block can accept a request; equals (count < DEPTH).
REQ-008 Port Imm26  input  26  is the instruction immediate field, bits [25:0].
REQ-009 Port Ctrl  input  3  selects the extension mode.
REQ-010 Port OldVal  input  WIDTH  is the prior register value used by MOVK.
REQ-011 Port OutValid  output  1  means the buffer head is valid.
REQ-012 Port OutReady  input  1  means the consumer accepts the head.
REQ-013 Port BusImm  output  WIDTH  is the extended immediate at the buffer head.
REQ-014 Port OutErr  output  1  means the head entry was an illegal request.
REQ-015 Port ErrCount  output  8  is the saturating count of accepted illegal requests.

Function
REQ-016 Accept on a CLK edge when InValid&&InReady; compute the result combinationally from the inputs; write the result and error into the buffer tail at that edge.
REQ-017 Latency: OutValid SHALL rise one cycle after acceptance into an empty buffer; throughput is 1/cycle while OutReady is held high.
REQ-018 Pop on a CLK edge when OutValid&&OutReady; FIFO order is preserved; BusImm/OutErr show the head, and show 0 when empty.
REQ-019 Push and pop on the same edge: count is unchanged and both take effect; with the buffer full, InReady=0, so no push occurs, and a pop that cycle raises InReady the next cycle.
REQ-020 Pointers SHALL wrap modulo DEPTH; count range is 0..DEPTH.
REQ-021 Ctrl=000 (I): sign-extend Imm26[21:10] to WIDTH.
REQ-022 Ctrl=001 (D): sign-extend Imm26[20:12] to WIDTH.
REQ-023 Ctrl=010 (B): sign-extend Imm26[25:0]; Ctrl=011 (CBZ): sign-extend Imm26[23:5]; scaling per REQ-031/032.
REQ-024 Ctrl=100 (MOVZ): Imm26[20:5] placed at bit 16*hw, where hw=Imm26[22:21], with other bits zero.
REQ-025 Ctrl=101 (MOVK): OldVal with bits [16*hw+15:16*hw] replaced by Imm26[20:5].
REQ-026 Ctrl=110 (MOVN): bitwise NOT of the MOVZ result.
REQ-027 Ctrl=111, or WIDTH=32 with hw>=2 in modes 100..110: result 0 and error 1; ErrCount increments at acceptance and saturates at 255.
REQ-028 No X on outputs for any Ctrl; the block SHALL NOT use $display.

Reset
REQ-029 Reset_n=0 at an edge: count, pointers and ErrCount SHALL clear to 0; OutValid=0, BusImm=0, OutErr=0, InReady=1 next cycle; in-flight entries are discarded.
REQ-030 Reset SHALL take priority over a simultaneous push or pop.

Configuration
REQ-031 With macro IMMX_BRANCH_SCALE_EN defined, B and CBZ results SHALL be shifted left by 2 after sign extension, with low bits zero.
REQ-032 With IMMX_BRANCH_SCALE_EN undefined, B and CBZ results SHALL be unscaled; all other modes are unaffected by the macro.

Verification
REQ-033 Scenario: WIDTH=64, Ctrl=000, Imm26[21:10]=12'hFFF, OutReady=1 -> next cycle OutValid=1, BusImm=64'hFFFF_FFFF_FFFF_FFFF, OutErr=0.
REQ-034 Scenario: Ctrl=101, hw=2, Imm26[20:5]=16'hBEEF, OldVal=64'h1111_2222_3333_4444 -> BusImm=64'h1111_BEEF_3333_4444.
REQ-035 Scenario: Ctrl=010, Imm26=26'h3FFFFFF -> BusImm=all ones without macro; 64'hFFFF_FFFF_FFFF_FFFC with IMMX_BRANCH_SCALE_EN.
REQ-036 Scenario: DEPTH=2, OutReady=0, 3 back-to-back requests -> InReady=0 after 2 accepts; third held; OutReady=1 -> all three emerge in order.
REQ-037 Scenario: WIDTH=32, Ctrl=100, hw=3 -> BusImm=0, OutErr=1, ErrCount=1; 300 illegal requests -> ErrCount=255.
REQ-038 Scenario: Reset_n=0 with 2 entries buffered -> next cycle OutValid=0, InReady=1, ErrCount=0.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle for imm_extend_pipe.
// Master drives requests and consumes results; slave is the extender.
interface imm_extend_pipe_if #(
    parameter int WIDTH = 64
);
    logic             InValid;
    logic             InReady;
    logic [25:0]      Imm26;
    logic [2:0]       Ctrl;
    logic [WIDTH-1:0] OldVal;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] BusImm;
    logic             OutErr;
    logic [7:0]       ErrCount;

    modport master (
        output InValid, Imm26, Ctrl, OldVal, OutReady,
        input  InReady, OutValid, BusImm, OutErr, ErrCount
    );

    modport slave (
        input  InValid, Imm26, Ctrl, OldVal, OutReady,
        output InReady, OutValid, BusImm, OutErr, ErrCount
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a DEPTH-entry output FIFO.
// Define IMMX_BRANCH_SCALE_EN to scale B/CBZ offsets by 4.
module imm_extend_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [25:0]      Imm26,
    input  logic [2:0]       Ctrl,
    input  logic [WIDTH-1:0] OldVal,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] BusImm,
    output logic             OutErr,
    output logic [7:0]       ErrCount
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    logic [1:0]       hw;
    logic [5:0]       msh;
    logic             bad_hw;
    logic [WIDTH-1:0] movz;
    logic [WIDTH-1:0] mmask;
    logic [WIDTH-1:0] brb;
    logic [WIDTH-1:0] cbz;
    logic [WIDTH-1:0] res_d;
    logic             ill_d;

    assign hw     = Imm26[22:21];
    assign msh    = {hw, 4'b0000};
    assign bad_hw = (WIDTH == 32) && hw[1];
    assign movz   = {{(WIDTH-16){1'b0}}, Imm26[20:5]} << msh;
    assign mmask  = {{(WIDTH-16){1'b0}}, 16'hFFFF} << msh;

`ifdef IMMX_BRANCH_SCALE_EN
    assign brb = {{(WIDTH-28){Imm26[25]}}, Imm26, 2'b00};
    assign cbz = {{(WIDTH-21){Imm26[23]}}, Imm26[23:5], 2'b00};
`else
    assign brb = {{(WIDTH-26){Imm26[25]}}, Imm26};
    assign cbz = {{(WIDTH-19){Imm26[23]}}, Imm26[23:5]};
`endif

    always_comb begin
        res_d = '0;
        ill_d = 1'b0;
        unique case (Ctrl)
            3'b000: res_d = {{(WIDTH-12){Imm26[21]}}, Imm26[21:10]};
            3'b001: res_d = {{(WIDTH-9){Imm26[20]}}, Imm26[20:12]};
            3'b010: res_d = brb;
            3'b011: res_d = cbz;
            3'b100: res_d = movz;
            3'b101: res_d = (OldVal & ~mmask) | movz;
            3'b110: res_d = ~movz;
            3'b111: ill_d = 1'b1;
        endcase
        // Wide-move halfwords beyond a 32-bit result are illegal
        if (Ctrl[2] && (Ctrl[1:0] != 2'b11) && bad_hw)
            ill_d = 1'b1;
        if (ill_d)
            res_d = '0;
    end

    logic [WIDTH-1:0] imm_q [DEPTH];
    logic             ill_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       ecnt_q, ecnt_d;
    logic             push;
    logic             pop;

    assign InReady  = (cnt_q < CFULL);
    assign OutValid = (cnt_q != '0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        ecnt_d = ecnt_q;
        if (push)
            wr_d = (wr_q == PLAST) ? '0 : wr_q + PW'(1);
        if (pop)
            rd_d = (rd_q == PLAST) ? '0 : rd_q + PW'(1);
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
        if (push && ill_d && (ecnt_q != 8'hFF))
            ecnt_d = ecnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ecnt_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    // Storage needs no reset: the count gates every read
    always_ff @(posedge CLK) begin
        if (push) begin
            imm_q[wr_q] <= res_d;
            ill_q[wr_q] <= ill_d;
        end
    end

    assign BusImm   = OutValid ? imm_q[rd_q] : '0;
    assign OutErr   = OutValid && ill_q[rd_q];
    assign ErrCount = ecnt_q;

endmodule
